// File: rtl/ap_seq_checker_pkg.sv
// Shared types for the arithmetic-progression checker: FSM states, the
// {borrow, diff} result pair and default widths.
package ap_pkg;

    localparam int AP_WIDTH = 8;
    localparam int AP_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        SECOND,
        RUN,
        DONE
    } ap_state_e;

    typedef struct packed {
        logic                borrow;
        logic [AP_WIDTH-1:0] diff;
    } ap_diff_t;

    // Two results only count as equal when the borrow matches too, so a
    // step that wraps around the modulus is a mismatch.
    function automatic logic ap_pair_differs(input ap_diff_t x, input ap_diff_t y);
        return (x.borrow != y.borrow) || (x.diff != y.diff);
    endfunction

endpackage

// File: rtl/ap_seq_checker_if.sv
// Term stream between the source (FIFO / register file) and the checker.
interface ap_seq_checker_if
    import ap_pkg::*;
#(
    parameter int WIDTH = AP_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ap_seq_checker_diff_unit.sv
// Combinational ripple-borrow subtractor: {bout, d} = a - b - bin.
module ap_diff_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH:0] borrow_chain;

    assign borrow_chain[0] = bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign d[gi] = a[gi] ^ b[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~a[gi] & b[gi])
                                      | (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign bout = borrow_chain[WIDTH];

endmodule

// File: rtl/ap_seq_checker.sv
// Burst arithmetic-progression checker: one shared subtractor computes one
// difference per accepted term and compares it with the first difference.
module ap_seq_checker
    import ap_pkg::*;
#(
    parameter int WIDTH = AP_WIDTH,
    parameter int LEN_W = AP_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    ap_seq_checker_if.slave  in_if,
    output logic             busy,
    output logic             done,
    output logic             is_ap,
    output logic [WIDTH-1:0] ap_diff,
    output logic             ap_borrow
);

    typedef struct packed {
        logic             borrow;
        logic [WIDTH-1:0] diff;
    } pair_t;

    ap_state_e        state_reg;
    logic [LEN_W-1:0] remaining_reg;
    logic [WIDTH-1:0] prev_reg;
    pair_t            ref_reg;
    logic             fail_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             is_ap_reg;
    logic [WIDTH-1:0] ap_diff_reg;
    logic             ap_borrow_reg;

    logic [WIDTH-1:0] sub_d;
    logic             sub_bout;
    pair_t            cur_pair;
    logic             accept;
    logic             last_term;
    logic             fail_next;

    // Single subtractor, always fed with the incoming term and the previous one.
    ap_diff_unit #(
        .WIDTH (WIDTH)
    ) u_diff (
        .a    (in_if.in_data),
        .b    (prev_reg),
        .bin  (1'b0),
        .d    (sub_d),
        .bout (sub_bout)
    );

    assign cur_pair  = '{borrow: sub_bout, diff: sub_d};
    assign accept    = in_if.in_valid & in_ready_reg;
    assign last_term = (remaining_reg == LEN_W'(1));
    assign fail_next = fail_reg | (cur_pair != ref_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            prev_reg      <= '0;
            ref_reg       <= '0;
            fail_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            is_ap_reg     <= 1'b0;
            ap_diff_reg   <= '0;
            ap_borrow_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        remaining_reg <= len;
                        fail_reg      <= 1'b0;
                        ap_diff_reg   <= '0;
                        ap_borrow_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        // Zero- or one-term bursts are trivially progressions.
                        if (len <= LEN_W'(1)) begin
                            state_reg <= DONE;
                            is_ap_reg <= 1'b1;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= FIRST;
                            is_ap_reg    <= 1'b0;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end

                FIRST: begin
                    if (accept) begin
                        prev_reg      <= in_if.in_data;
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        state_reg     <= SECOND;
                    end
                end

                SECOND: begin
                    if (accept) begin
                        ref_reg       <= cur_pair;
                        ap_diff_reg   <= sub_d;
                        ap_borrow_reg <= sub_bout;
                        prev_reg      <= in_if.in_data;
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (last_term) begin
                            state_reg    <= DONE;
                            is_ap_reg    <= 1'b1;
                            done_reg     <= 1'b1;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end

                RUN: begin
                    // A mismatch is only recorded; the burst is always drained
                    // so the source stays aligned with the next start.
                    if (accept) begin
                        fail_reg      <= fail_next;
                        prev_reg      <= in_if.in_data;
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (last_term) begin
                            state_reg    <= DONE;
                            is_ap_reg    <= ~fail_next;
                            done_reg     <= 1'b1;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg    <= IDLE;
                    busy_reg     <= 1'b0;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign is_ap          = is_ap_reg;
    assign ap_diff        = ap_diff_reg;
    assign ap_borrow      = ap_borrow_reg;

endmodule

// File: tb/tb_ap_seq_checker.sv
// Directed bench for ap_seq_checker: expected results are queued at start
// and a done-triggered monitor pops and compares them.
module tb_ap_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy, done, is_ap, ap_borrow;
    logic [7:0] ap_diff;

    ap_seq_checker_if #(.WIDTH(8)) sif ();

    ap_seq_checker #(
        .WIDTH (8),
        .LEN_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_if     (sif),
        .busy      (busy),
        .done      (done),
        .is_ap     (is_ap),
        .ap_diff   (ap_diff),
        .ap_borrow (ap_borrow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_ap;
        logic [7:0] diff;
        logic       borrow;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 with no burst outstanding at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                $display("result: is_ap=%0d ap_diff=0x%02h ap_borrow=%0d (expected %0d/0x%02h/%0d)",
                         is_ap, ap_diff, ap_borrow, e.is_ap, e.diff, e.borrow);
                chk("is_ap", int'(is_ap), int'(e.is_ap));
                chk("ap_diff", int'(ap_diff), int'(e.diff));
                chk("ap_borrow", int'(ap_borrow), int'(e.borrow));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_term(input logic [7:0] d, input int gap, output int hs_cyc);
        bit ok = 0;
        if (gap > 0) begin
            sif.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sif.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready=0 for 50 cycles on term 0x%02h, expected 1", d);
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        sif.in_valid = 1'b0;
        $display("term 0x%02h accepted at cycle %0d", d, hs_cyc);
    endtask

    task automatic burst(input logic [7:0] l, input int gap, input exp_t e);
        int hs, first_hs, last_hs;
        first_hs = 0;
        last_hs  = 0;
        start = 1'b1;
        len   = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        foreach (tq[i]) begin
            send_term(tq[i], gap, hs);
            if (i == 0) first_hs = hs;
            last_hs = hs;
        end
        @(negedge clk);
        chk("done_after_last_term", int'(done), 1);
        chk("in_ready_after_last_term", int'(sif.in_ready), 0);
        chk("handshake_span", last_hs - first_hs, (int'(l) - 1) * (gap + 1));
        @(posedge clk);
        #1;
        chk("busy_cleared", int'(busy), 0);
    endtask

    task automatic short_burst(input logic [7:0] l, input bit restart_in_done);
        bit ready_seen = 0;
        start = 1'b1;
        len   = l;
        sb.push_back('{1'b1, 8'h00, 1'b0});
        @(posedge clk);
        #1;
        start = restart_in_done;
        @(negedge clk);
        ready_seen = sif.in_ready;
        chk("short_done", int'(done), 1);
        chk("short_busy_in_done", int'(busy), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        ready_seen = ready_seen | sif.in_ready;
        chk("short_busy_after", int'(busy), 0);
        chk("short_no_second_done", int'(done), 0);
        @(posedge clk);
        #1;
        ready_seen = ready_seen | sif.in_ready;
        chk("short_in_ready_never", int'(ready_seen), 0);
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_in_ready", int'(sif.in_ready), 0);
        chk("reset_is_ap", int'(is_ap), 0);
        chk("reset_ap_diff", int'(ap_diff), 0);
        chk("reset_ap_borrow", int'(ap_borrow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rising progression, back-to-back terms; done is the 8th cycle
        // counting the first handshake cycle as cycle 1.
        tq = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd13, 8'd15};
        burst(8'd7, 0, '{1'b1, 8'h02, 1'b0});
        @(negedge clk);
        chk("hold_is_ap", int'(is_ap), 1);
        chk("hold_ap_diff", int'(ap_diff), 8'h02);
        @(posedge clk);
        #1;

        // Falling progression: step of -3 borrows every time.
        tq = '{8'd20, 8'd17, 8'd14, 8'd11, 8'd8, 8'd5, 8'd2};
        burst(8'd7, 0, '{1'b1, 8'hFD, 1'b1});

        // Same modular step but the second one wraps, so borrow differs.
        tq = '{8'd250, 8'd253, 8'd0};
        burst(8'd3, 0, '{1'b0, 8'h03, 1'b0});

        // Gapped stream with a broken last step.
        tq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
        burst(8'd5, 2, '{1'b0, 8'h01, 1'b0});

        // Degenerate bursts; the first also retries start during DONE.
        short_burst(8'd1, 1'b1);
        short_burst(8'd0, 1'b0);

        // Reset mid-burst after three of six terms.
        begin : mid_reset
            int hs;
            start = 1'b1;
            len   = 8'd6;
            sb.push_back('{1'b0, 8'h00, 1'b0});
            @(posedge clk);
            #1;
            start = 1'b0;
            send_term(8'd10, 0, hs);
            send_term(8'd20, 0, hs);
            send_term(8'd30, 0, hs);
            rst_n = 1'b0;
            #1;
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_in_ready", int'(sif.in_ready), 0);
            chk("midrst_done", int'(done), 0);
            chk("midrst_is_ap", int'(is_ap), 0);
            chk("midrst_ap_diff", int'(ap_diff), 0);
            chk("midrst_ap_borrow", int'(ap_borrow), 0);
            sb.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end

        tq = '{8'd9, 8'd4};
        burst(8'd2, 0, '{1'b1, 8'hFB, 1'b1});

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
